// File: rtl/rf_param_if.sv
// Register-file port bundle: two read ports, one write port
// and the bulk-clear request/status pair.
interface rf_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Rs_Addr;
  logic [ADDR_W-1:0] Rt_Addr;
  logic [DATA_W-1:0] Rs_Data;
  logic [DATA_W-1:0] Rt_Data;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd_Addr;
  logic [DATA_W-1:0] Rd_Data;
  logic              Clr_Req;
  logic              Busy;
  logic              Clr_Done;

  modport master (
    output Rs_Addr, Rt_Addr,
    output RegWrite, Rd_Addr, Rd_Data,
    output Clr_Req,
    input  Rs_Data, Rt_Data,
    input  Busy, Clr_Done
  );

  modport slave (
    input  Rs_Addr, Rt_Addr,
    input  RegWrite, Rd_Addr, Rd_Data,
    input  Clr_Req,
    output Rs_Data, Rt_Data,
    output Busy, Clr_Done
  );
endinterface

// File: rtl/rf_param.sv
// Parametrised 2R1W register file with optional zero register,
// write bypass and a one-entry-per-cycle bulk-clear engine.
module rf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic      clk,
  input logic      rst_n,
  rf_param_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] R [DEPTH];

  logic              busy;
  logic              wr_zero;
  logic              we;
  logic [DATA_W-1:0] rs;
  logic [DATA_W-1:0] rt;

  assign busy    = (state_q == CLEAR);
  assign wr_zero = ZR && (rf.Rd_Addr == '0);
  assign we      = rf.RegWrite && !busy && !wr_zero;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rf.Clr_Req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      done_q    <= done_d;
    end
  end

  // clear and write never collide: we is gated by busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) R[i] <= '0;
    end else if (busy) begin
      R[clr_idx_q] <= '0;
    end else if (we) begin
      R[rf.Rd_Addr] <= rf.Rd_Data;
    end
  end

  always_comb begin
    rs = R[rf.Rs_Addr];
    if (BP && we && rf.Rd_Addr == rf.Rs_Addr) rs = rf.Rd_Data;
    if (ZR && rf.Rs_Addr == '0) rs = '0;
  end

  always_comb begin
    rt = R[rf.Rt_Addr];
    if (BP && we && rf.Rd_Addr == rf.Rt_Addr) rt = rf.Rd_Data;
    if (ZR && rf.Rt_Addr == '0) rt = '0;
  end

  assign rf.Rs_Data  = rs;
  assign rf.Rt_Data  = rt;
  assign rf.Busy     = busy;
  assign rf.Clr_Done = done_q;
endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: random traffic against a behavioural model
// plus directed checks on several parameter sets.
module tb_rf_param;
  logic clk;
  logic rst_n;

  rf_param_if #(.DATA_W(32), .ADDR_W(5)) a ();
  rf_param_if #(.DATA_W(32), .ADDR_W(5)) z ();
  rf_param_if #(.DATA_W(32), .ADDR_W(5)) b ();
  rf_param_if #(.DATA_W(16), .ADDR_W(3)) s ();

  rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
    u_a (.clk(clk), .rst_n(rst_n), .rf(a.slave));
  rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1))
    u_z (.clk(clk), .rst_n(rst_n), .rf(z.slave));
  rf_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
    u_b (.clk(clk), .rst_n(rst_n), .rf(b.slave));
  rf_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1))
    u_s (.clk(clk), .rst_n(rst_n), .rf(s.slave));

  int n_chk;
  int n_fail;
  bit chk_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of instance a: array contents, edge count, clear start edge.
  logic [31:0] m [32];
  int k;
  int cb;
  bit done_exp;

  function automatic bit busy_at(input int e);
    return (cb >= 0) && (e >= cb) && (e < cb + 32);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] ad);
    if (ad == 5'd0) return 32'd0;
    if (a.RegWrite && !busy_at(k) && a.Rd_Addr == ad) return a.Rd_Data;
    return m[ad];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      k = 0;
      cb = -1000;
      done_exp = 1'b0;
    end else begin : upd
      bit pb;
      k++;
      pb = busy_at(k - 1);
      if (pb) begin
        m[k - cb - 1] = 32'd0;
      end else begin
        if (a.RegWrite && a.Rd_Addr != 5'd0) m[a.Rd_Addr] = a.Rd_Data;
        if (a.Clr_Req) cb = k;
      end
      done_exp = (cb >= 0) && (k == cb + 32);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rs", a.Rs_Data, exp_rd(a.Rs_Addr));
      chk("rt", a.Rt_Data, exp_rd(a.Rt_Addr));
      chk("busy", 32'(a.Busy), 32'(busy_at(k)));
      chk("clr_done", 32'(a.Clr_Done), 32'(done_exp));
    end
  end

  initial begin : main
    int n;
    int dn;
    bit pbz;

    n_chk = 0;
    n_fail = 0;
    chk_en = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    k = 0;
    cb = -1000;
    done_exp = 1'b0;
    rst_n = 1'b0;
    a.Rs_Addr = 5'd9; a.Rt_Addr = 5'd0; a.RegWrite = 0;
    a.Rd_Addr = 0; a.Rd_Data = 0; a.Clr_Req = 0;
    z.Rs_Addr = 0; z.Rt_Addr = 0; z.RegWrite = 0;
    z.Rd_Addr = 0; z.Rd_Data = 0; z.Clr_Req = 0;
    b.Rs_Addr = 0; b.Rt_Addr = 0; b.RegWrite = 0;
    b.Rd_Addr = 0; b.Rd_Data = 0; b.Clr_Req = 0;
    s.Rs_Addr = 3'd5; s.Rt_Addr = 0; s.RegWrite = 0;
    s.Rd_Addr = 0; s.Rd_Data = 0; s.Clr_Req = 0;

    #2;
    chk("rst_busy", 32'(a.Busy), 32'd0);
    chk("rst_done", 32'(a.Clr_Done), 32'd0);
    chk("rst_rd", a.Rs_Data, 32'd0);
    chk("rst_rd_s", 32'(s.Rs_Data), 32'd0);
    #10;
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // bypass vs stored value
    a.RegWrite = 1; a.Rd_Addr = 5'd1; a.Rd_Data = 32'h1111_1111;
    step();
    a.Rd_Addr = 5'd2; a.Rd_Data = 32'hFFFF_FFFF;
    a.Rs_Addr = 5'd2; a.Rt_Addr = 5'd1;
    #2;
    chk("bypass_rs", a.Rs_Data, 32'hFFFF_FFFF);
    chk("bypass_rt", a.Rt_Data, 32'h1111_1111);
    step();
    a.RegWrite = 0;
    #2;
    chk("stored_rs", a.Rs_Data, 32'hFFFF_FFFF);

    // zero register on/off
    a.RegWrite = 1; a.Rd_Addr = 0; a.Rd_Data = 32'h8787_8787;
    z.RegWrite = 1; z.Rd_Addr = 0; z.Rd_Data = 32'h8787_8787;
    step();
    a.RegWrite = 0; z.RegWrite = 0;
    a.Rs_Addr = 0; a.Rt_Addr = 0; z.Rs_Addr = 0; z.Rt_Addr = 0;
    #2;
    chk("zr_rs", a.Rs_Data, 32'd0);
    chk("zr_rt", a.Rt_Data, 32'd0);
    chk("nzr_rs", z.Rs_Data, 32'h8787_8787);
    chk("nzr_rt", z.Rt_Data, 32'h8787_8787);

    // no bypass
    b.RegWrite = 1; b.Rd_Addr = 5'd3; b.Rd_Data = 32'hA5A5_A5A5;
    step();
    b.Rd_Data = 32'h1234_5678; b.Rs_Addr = 5'd3;
    #2;
    chk("nobyp_before", b.Rs_Data, 32'hA5A5_A5A5);
    step();
    b.RegWrite = 0;
    #2;
    chk("nobyp_after", b.Rs_Data, 32'h1234_5678);

    // bulk clear over a full array
    for (int i = 0; i < 32; i++) begin
      a.RegWrite = 1; a.Rd_Addr = 5'(i); a.Rd_Data = 32'hDEAD_BEEF;
      step();
    end
    a.RegWrite = 0;
    a.Clr_Req = 1;
    step();
    a.Clr_Req = 0;
    n = 0; dn = 0; pbz = 0;
    for (int c = 0; c < 40; c++) begin
      a.RegWrite = (c == 3); a.Rd_Addr = 5'd5; a.Rd_Data = 32'h5555_5555;
      #2;
      if (a.Busy) n++;
      if (a.Clr_Done) begin
        dn++;
        chk("done_after_busy", 32'(pbz), 32'd1);
      end
      pbz = a.Busy;
      step();
    end
    a.RegWrite = 0;
    chk("clr_busy_cycles", 32'(n), 32'd32);
    chk("clr_done_pulses", 32'(dn), 32'd1);
    for (int i = 0; i < 32; i++) begin
      a.Rs_Addr = 5'(i);
      #1;
      chk("cleared", a.Rs_Data, 32'd0);
    end
    step();

    // reset in the middle of a clear
    a.RegWrite = 1; a.Rd_Addr = 5'd20; a.Rd_Data = 32'h2020_2020;
    step();
    a.RegWrite = 0;
    a.Clr_Req = 1;
    step();
    a.Clr_Req = 0;
    repeat (10) step();
    a.Rs_Addr = 5'd9; a.Rt_Addr = 5'd20;
    #1;
    chk("mid_low", a.Rs_Data, 32'd0);
    chk("mid_high", a.Rt_Data, 32'h2020_2020);
    chk("mid_busy", 32'(a.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(a.Busy), 32'd0);
    chk("arst_rd", a.Rt_Data, 32'd0);
    rst_n = 1'b1;
    step();
    a.RegWrite = 1; a.Rd_Addr = 5'd7; a.Rd_Data = 32'h7777_7777;
    step();
    a.RegWrite = 0; a.Rs_Addr = 5'd7;
    #2;
    chk("post_rst_wr", a.Rs_Data, 32'h7777_7777);

    // narrow instance
    s.Clr_Req = 1;
    step();
    s.Clr_Req = 0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (s.Busy) n++;
      step();
    end
    chk("s_busy_cycles", 32'(n), 32'd8);
    s.RegWrite = 1; s.Rd_Addr = 3'd7; s.Rd_Data = 16'hBEEF;
    step();
    s.RegWrite = 0; s.Rs_Addr = 3'd7;
    #2;
    chk("s_rd", 32'(s.Rs_Data), 32'h0000_BEEF);

    // random traffic on a
    for (int c = 0; c < 800; c++) begin
      a.RegWrite = ($urandom_range(0, 2) != 0);
      a.Rd_Addr  = 5'($urandom_range(0, 31));
      a.Rd_Data  = $urandom;
      a.Rs_Addr  = ($urandom_range(0, 3) == 0) ? a.Rd_Addr
                                               : 5'($urandom_range(0, 31));
      a.Rt_Addr  = ($urandom_range(0, 3) == 0) ? a.Rd_Addr
                                               : 5'($urandom_range(0, 31));
      a.Clr_Req  = ($urandom_range(0, 39) == 0);
      step();
    end
    a.RegWrite = 0;
    a.Clr_Req = 0;
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_param.md
# rf_param

Parametrised MIPS-style register file for the datapath: two asynchronous read ports (Rs, Rt), one synchronous write port (Rd), optional hardwired-zero R0 and optional write-to-read bypass. A sequential bulk-clear engine zeroes the whole array on request, one entry per cycle, and signals completion. It is the drop-in successor to the fixed 32x32 register file, and the CPU top instantiates it with defaults.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1: 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1: 1 = a read of the address being written this cycle returns Rd_Data; 0 = the read returns the stored value.

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs_Addr  in  ADDR_W  read port A address.
- Rt_Addr  in  ADDR_W  read port B address.
- Rs_Data  out  DATA_W  read port A data (combinational).
- Rt_Data  out  DATA_W  read port B data (combinational).
- RegWrite  in  1  write enable.
- Rd_Addr  in  ADDR_W  write address.
- Rd_Data  in  DATA_W  write data.
- Clr_Req  in  1  bulk-clear request; sampled only in IDLE.
- Busy  out  1  high while the clear engine is active.
- Clr_Done  out  1  one-cycle pulse after the last entry is cleared.

## Operation
- Storage array is named R, indexed 0..DEPTH-1, and is hierarchically accessible so benches can preload it.
- Effective write: we = RegWrite & ~Busy & ~(ZERO_REG & Rd_Addr==0). When we is high, R[Rd_Addr] <= Rd_Data at the rising edge.
- Read: Rs_Data = 0 if ZERO_REG and Rs_Addr==0. Otherwise it is Rd_Data if BYPASS and we and Rd_Addr==Rs_Addr. Otherwise it is R[Rs_Addr]. Rt is identical. Both ports may address the same entry.
- FSM states are IDLE and CLEAR, with counter Clr_Idx (ADDR_W bits).
  - IDLE: Clr_Req=1 at an edge moves to CLEAR with Clr_Idx<=0.
  - CLEAR: each edge sets R[Clr_Idx]<=0 and Clr_Idx<=Clr_Idx+1. At the edge where Clr_Idx==DEPTH-1, the engine returns to IDLE and sets Clr_Done<=1.
  - Busy = (state==CLEAR).
- Writes while Busy=1 are dropped entirely: no storage update and no bypass. The write source must hold or retry.
- Clr_Req while Busy=1 is ignored and is not queued. Clr_Req held high after completion starts a new clear in the next IDLE cycle.
- Reads while Busy=1 are allowed. Entries below Clr_Idx read 0; others read their old value.
- Reset (rst_n=0, any time, including mid-clear): all R entries go to 0, state to IDLE, Clr_Idx to 0, Clr_Done to 0. The effect is immediate, not waiting for clk.

## Timing
- Read latency is 0 cycles (combinational from address, and from Rd_Data/RegWrite when BYPASS=1).
- A write is visible to a non-bypassed read after the rising edge at which it is taken.
- Clear occupancy: Busy is high for exactly DEPTH cycles, starting the cycle after the Clr_Req edge. Clr_Done is high in the single cycle after Busy falls.
- Reset values: Busy=0, Clr_Done=0. Rs_Data and Rt_Data are 0 for any address, because the array is zero (bypass may still forward a write).
- Clr_Idx wrap from DEPTH-1 to 0 coincides with the return to IDLE; there is no extra cycle.
- A write issued in the same cycle as the Clr_Req edge from IDLE is taken, because Busy is still 0. Clear then overwrites that entry later.

## Test plan
- Preload via hierarchy R[1]=0x11111111. Then RegWrite=1, Rd_Addr=2, Rd_Data=0xFFFFFFFF, Rs_Addr=2, Rt_Addr=1.
  - Before the edge: Rs_Data=0xFFFFFFFF (bypass), Rt_Data=0x11111111.
  - After the edge with RegWrite=0: Rs_Data=0xFFFFFFFF from storage.
- ZERO_REG: write 0x87878787 to address 0, then read Rs_Addr=Rt_Addr=0 -> both 0. Rebuild with ZERO_REG=0 -> both 0x87878787 after the edge.
- BYPASS=0: write 0x12345678 to address 3 while Rs_Addr=3 holding old 0xA5A5A5A5.
  - Before the edge: Rs_Data=0xA5A5A5A5. After the edge: 0x12345678.
- Bulk clear with all entries preloaded to 0xDEADBEEF and Clr_Req pulsed for one cycle:
  - Busy is high for exactly 32 cycles, then Clr_Done pulses once, then all 32 entries read 0.
  - A RegWrite to address 5 during Busy is dropped, and address 5 reads 0 after Clr_Done.
- Reset mid-clear: assert rst_n=0 at Clr_Idx=10, between edges -> Busy=0 immediately, all entries read 0, state IDLE. Release reset, then a write and read to address 7 work normally.
- Parameter sweep with DATA_W=16, ADDR_W=3: Busy lasts 8 cycles, and a write of 0xBEEF to address 7 reads back as 0xBEEF.
